// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble) for the MDR operand input path.
// One shift/correct iteration per cycle; result, overflow and invalid-digit flags are held after done.
module bcd_to_bin #(
    parameter int N_DIGITS = 5,
    parameter int W_OUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    output logic [W_OUT-1:0]        bin_out,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic                    err
);

    localparam int W_INT = 4 * N_DIGITS;
    localparam int W_CNT = $clog2(W_INT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PROCESING = 2'd1,
        READY     = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [W_INT-1:0]   r_bcd;
    logic [W_INT-1:0]   r_bin;
    logic [W_CNT-1:0]   r_cnt;

    logic [2*W_INT-1:0] w_shift;
    logic [W_INT-1:0]   w_bcd_next;
    logic [W_INT-1:0]   w_bin_next;
    logic               w_invalid;
    logic               w_last;
    logic               w_ovf;

    function automatic logic has_bad_digit(input logic [W_INT-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Undo the x2 carry of a decimal digit after a right shift: digit >= 8 means -3.
    function automatic logic [W_INT-1:0] correct_digits(input logic [W_INT-1:0] v);
        logic [W_INT-1:0] res;
        res = v;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd8) res[4*i +: 4] = v[4*i +: 4] - 4'd3;
        end
        return res;
    endfunction

    always_comb begin
        w_shift    = {r_bcd, r_bin} >> 1;
        w_bcd_next = correct_digits(w_shift[2*W_INT-1:W_INT]);
        w_bin_next = w_shift[W_INT-1:0];
        w_invalid  = has_bad_digit(bcd_in);
        w_last     = (r_cnt == W_CNT'(W_INT - 1));
        w_ovf      = ((w_bin_next >> W_OUT) != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (start) w_state_next = w_invalid ? READY : PROCESING;
            PROCESING: if (w_last) w_state_next = READY;
            READY:     w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    assign busy = (r_state == PROCESING);
    assign done = (r_state == READY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            bin_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_invalid) begin
                            err     <= 1'b1;
                            ovf     <= 1'b0;
                            bin_out <= '0;
                        end else begin
                            r_bcd <= bcd_in;
                            r_bin <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                PROCESING: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= w_bin_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        err     <= 1'b0;
                        ovf     <= w_ovf;
                        bin_out <= w_ovf ? '1 : w_bin_next[W_OUT-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed and table-driven bench for bcd_to_bin: latency, busy window, done pulse,
// saturation/overflow, invalid digits, start-while-busy, reset mid-conversion, random sweep.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] bcd_in;
    logic [15:0] bin_out;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_to_bin #(.N_DIGITS(5), .W_OUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [19:0] bcd;
        logic [15:0] bin;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Starts one conversion and checks latency, busy window, outputs, pulse width and hold.
    task automatic do_vector(input string name, input logic [19:0] bcd,
                             input logic [15:0] exp_bin, input logic exp_ovf, input logic exp_err);
        int lat;
        int busy_cnt;
        int exp_lat;
        exp_lat  = exp_err ? 0 : 20;
        bcd_in   = bcd;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        bcd_in   = 20'hFFFFF;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check({name, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({name, ".bin_out"}, 32'(bin_out), 32'(exp_bin));
        check({name, ".ovf"}, 32'(ovf), 32'(exp_ovf));
        check({name, ".err"}, 32'(err), 32'(exp_err));
        tick();
        check({name, ".done_pulse"}, 32'(done), 32'd0);
        check({name, ".bin_hold"}, 32'(bin_out), 32'(exp_bin));
    endtask

    initial begin
        int k;
        int first_done;
        int second_done;
        int done_seen;
        int v;
        logic [15:0] first_bin;
        logic [15:0] second_bin;
        logic [15:0] exp_bin;
        logic        exp_ovf;

        vecs[0] = '{20'h12345, 16'h3039, 1'b0, 1'b0};
        vecs[1] = '{20'h65535, 16'hFFFF, 1'b0, 1'b0};
        vecs[2] = '{20'h65536, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{20'h1A345, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{20'h00000, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{20'h99999, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{20'h0000F, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{20'h09999, 16'h270F, 1'b0, 1'b0};
        vecs[8] = '{20'h65534, 16'hFFFE, 1'b0, 1'b0};
        vecs[9] = '{20'h00042, 16'h002A, 1'b0, 1'b0};

        rst    = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        #23;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.bin_out", 32'(bin_out), 32'd0);
        check("reset.ovf", 32'(ovf), 32'd0);
        check("reset.err", 32'(err), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            do_vector($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].ovf, vecs[i].err);
        end

        // Invalid digit then a valid start two edges later.
        do_vector("inv_then", 20'hA0000, 16'h0000, 1'b0, 1'b1);
        do_vector("after_inv", 20'h00777, 16'h0309, 1'b0, 1'b0);

        // start held for 30 cycles while bcd_in changes mid-conversion.
        bcd_in      = 20'h00100;
        start       = 1'b1;
        tick();
        first_done  = -1;
        second_done = -1;
        first_bin   = '0;
        second_bin  = '0;
        for (k = 1; k <= 50; k++) begin
            tick();
            if (k == 5) bcd_in = 20'h00777;
            if (k == 30) start = 1'b0;
            if (k == 21) check("hold.idle_busy", 32'(busy), 32'd0);
            if (k == 22) check("hold.restart_busy", 32'(busy), 32'd1);
            if (done) begin
                if (first_done < 0) begin
                    first_done = k;
                    first_bin  = bin_out;
                end else if (second_done < 0) begin
                    second_done = k;
                    second_bin  = bin_out;
                end
            end
        end
        check("hold.first_done", 32'(first_done), 32'd20);
        check("hold.first_bin", 32'(first_bin), 32'h64);
        check("hold.second_done", 32'(second_done), 32'd42);
        check("hold.second_bin", 32'(second_bin), 32'h309);
        tick();

        // Reset in the middle of a conversion.
        bcd_in = 20'h12345;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.bin_out", 32'(bin_out), 32'd0);
        check("midrst.ovf", 32'(ovf), 32'd0);
        check("midrst.err", 32'(err), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (done || busy) done_seen++;
            tick();
        end
        check("midrst.no_done", 32'(done_seen), 32'd0);
        do_vector("midrst.after", 20'h00042, 16'h002A, 1'b0, 1'b0);

        // Back-to-back random sweep against an arithmetic reference.
        for (int i = 0; i < 20; i++) begin
            v = (i == 0) ? 65536 : int'($urandom_range(0, 99999));
            exp_ovf = (v > 65535);
            exp_bin = exp_ovf ? 16'hFFFF : 16'(v);
            do_vector($sformatf("sweep%0d_%0d", i, v), to_bcd(v), exp_bin, exp_ovf, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter for the MDR operand input path. It accepts a packed multi-digit BCD operand, as entered by the user one decimal digit per nibble, and converts it to an unsigned binary operand with a reverse double-dabble datapath. It uses the IDLE/PROCESING/READY state encoding (`state_e`) from `definitions_pkg`. It is the input-side counterpart of the binary→BCD→segment display path and feeds the MDR arithmetic core.

## Interface
- `N_DIGITS`, default 5: number of BCD digits accepted.
- `W_OUT`, default 16 (`w_INT16`): binary output width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `bcd_in`  in  4*N_DIGITS  packed BCD; nibble [3:0] is the units digit, the top nibble is the most-significant digit.
- `bin_out`  out  W_OUT  converted value; held until the next completion.
- `busy`  out  1  high while the state is PROCESING.
- `done`  out  1  one-cycle pulse while the state is READY.
- `ovf`  out  1  value > 2^W_OUT−1; valid with `done`, held afterwards.
- `err`  out  1  invalid BCD digit detected; valid with `done`, held afterwards.

## Operation
- **Reset values:** state IDLE; `bin_out`=0; `busy`, `done`, `ovf`, `err` = 0; all internal registers 0.
- **Internal registers:**
  - Shift register R = {bcd_r[4*N_DIGITS−1:0], bin_r[4*N_DIGITS−1:0]}.
  - Iteration counter sized for 0..4*N_DIGITS.
- **IDLE:** if `start`=1 at an edge, check every digit of `bcd_in`.
  - Any digit > 9: go to READY. Set `err`=1, `ovf`=0, `bin_out`=0.
  - All digits valid: load bcd_r←`bcd_in`, bin_r←0, counter←0, then go to PROCESING.
- **PROCESING:** one iteration per edge.
  - Shift R right by 1.
  - Then, in each 4-bit digit of the shifted bcd_r, subtract 3 if the digit ≥ 8. All digits are corrected in parallel, in the same cycle as the shift.
  - Increment the counter.
  - On the edge that completes iteration 4*N_DIGITS, go to READY. On that same edge, load the outputs:
    - If bin_r bits [4*N_DIGITS−1:W_OUT] are nonzero: `ovf`=1 and `bin_out` saturates to all ones.
    - Otherwise: `ovf`=0 and `bin_out`=bin_r[W_OUT−1:0].
    - In both cases `err`=0.
- **READY:** `done`=1 for exactly one cycle, then go to IDLE unconditionally. `start` is ignored in READY.
- `start` is ignored while PROCESING; the in-flight conversion is unaffected.
- Outputs are unsigned only. Sign handling belongs to the caller (SIGN segment path).
- Width rule: internal binary width is 4*N_DIGITS. This is ≥ W_OUT whenever 10^N_DIGITS − 1 ≥ 2^W_OUT − 1; the defaults give 20 ≥ 16.
- **Reset mid-operation:** asynchronous return to the reset values; the partial result is discarded with no `done`.

## Timing
- **Valid input:**
  - `start` sampled at edge E0.
  - `busy`=1 from after E0 until E(4*N_DIGITS).
  - At E(4*N_DIGITS), i.e. E20 by default: `busy`=0, `done`=1, `bin_out`/`ovf`/`err` updated.
  - At E(4*N_DIGITS+1): `done`=0, state IDLE.
  - The earliest next `start` is sampled at E(4*N_DIGITS+2).
  - Latency start→done is 20 cycles; throughput is one conversion per 22 cycles.
- **Invalid input:**
  - `start` sampled at E0; `done`=1 and `err`=1 right after E0, with `busy` never asserted.
  - Next `start` is accepted at E2.
- `bcd_in` must be stable only at the sampling edge E0; it is not re-read afterwards.
- `bin_out`, `ovf` and `err` change only at the edge entering READY, or on reset.

## Test plan
- **Nominal conversion:** `bcd_in`=0x12345, pulse `start` → `done` exactly 20 cycles later with `bin_out`=0x3039, `ovf`=0, `err`=0; `busy` high for exactly 20 cycles.
- **Boundaries:**
  - `bcd_in`=0x65535 → `bin_out`=0xFFFF, `ovf`=0.
  - `bcd_in`=0x65536 → `bin_out`=0xFFFF, `ovf`=1.
  - `bcd_in`=0x00000 → `bin_out`=0, `ovf`=0.
- **Invalid digit:** `bcd_in`=0x1A345 → `done` one cycle after `start`, `err`=1, `bin_out`=0, `busy` never high. The next valid `start` 2 cycles later converts correctly.
- **Start during busy:** `start` held high for 30 cycles with `bcd_in` changed mid-conversion → first result reflects the value at E0. The second conversion begins at E22, the next sampled IDLE edge.
- **Reset mid-operation:** assert `rst`=0 at cycle 10 of a conversion → all outputs 0 immediately and no `done`. After release, `bcd_in`=0x00042 → `bin_out`=0x002A.
- **Back-to-back sweep:** random valid BCD 0..99999 against a reference model. Check `ovf` exactly when value > 65535, and that `done` is a single-cycle pulse every time.
